s2p_align_ctrl: RTL and testbench

//   Sequencing and alignment controller for the 4-lane serial-to-parallel front end.

---
 rtl/s2p_align_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_s2p_align_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/s2p_align_ctrl.sv
// s2p_align_ctrl
//   Sequencing and alignment controller for the 4-lane serial-to-parallel
//   front end. Drives ENB/MODO/DIR to the s2p lane registers. Searches lane 0
//   for a comma byte and locks byte and frame alignment. While locked it
//   issues a LOAD strobe at every aligned byte boundary. Lanes 1-3 follow
//   lane 0 timing.
//
//   Optional feature macro: S2P_CTRL_ERR_CNT_EN
//     When defined, err_cnt counts comma mismatches seen while locked. The
//     count saturates at 8'hFF and is cleared only by reset.
//     When undefined, err_cnt is tied to zero.
//
// Ports
//   CLK      in   clock, rising edge
//   reset    in   synchronous active-high reset
//   start    in   run request; low returns to IDLE at the next edge
//   dir_cfg  in   shift direction, sampled only while IDLE
//   P0[7:0]  in   lane-0 s2p register contents
//   ENB      out  enable to all s2p lanes / ffd stages
//   MODO[1:0] out s2p mode: 00 hold, 01 serial shift
//   DIR      out  registered shift direction
//   LOAD     out  strobe: lanes hold an aligned byte at the coming edge
//   LOCKED   out  alignment locked
//   bit_cnt[2:0] out bits shifted since last aligned byte, mod 8
//   err_cnt[7:0] out locked comma error count (see macro above)
module s2p_align_ctrl #(
    parameter logic [7:0]  COMMA     = 8'hBC,
    parameter int unsigned FRAME_LEN = 4,
    parameter int unsigned LOCK_CNT  = 3,
    parameter int unsigned MISS_MAX  = 2
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       start,
    input  logic       dir_cfg,
    input  logic [7:0] P0,
    output logic       ENB,
    output logic [1:0] MODO,
    output logic       DIR,
    output logic       LOAD,
    output logic       LOCKED,
    output logic [2:0] bit_cnt,
    output logic [7:0] err_cnt
);

    localparam logic [3:0] LAST_BYTE = 4'(FRAME_LEN - 1);
    localparam logic [3:0] LOCK_TGT  = 4'(LOCK_CNT);
    localparam logic [3:0] MISS_TGT  = 4'(MISS_MAX);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_SYNC,
        ST_LOCK
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] bit_nxt;
    logic [3:0] byte_cnt, byte_nxt;
    logic [3:0] good_cnt, good_nxt;
    logic [3:0] miss_cnt, miss_nxt;

    logic boundary;
    logic comma_slot;
    logic comma_ok;

    // A boundary only has meaning once alignment has been found.
    assign boundary   = (bit_cnt == 3'd0) && (state == ST_SYNC || state == ST_LOCK);
    assign comma_slot = boundary && (byte_cnt == 4'd0);
    assign comma_ok   = (P0 == COMMA);

    always_ff @(posedge CLK) begin
        if (reset) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            good_cnt <= '0;
            miss_cnt <= '0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_nxt;
            byte_cnt <= byte_nxt;
            good_cnt <= good_nxt;
            miss_cnt <= miss_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_cnt + 3'd1;
        byte_nxt  = byte_cnt;
        good_nxt  = good_cnt;
        miss_nxt  = miss_cnt;

        if (boundary) begin
            byte_nxt = (byte_cnt == LAST_BYTE) ? 4'd0 : byte_cnt + 4'd1;
        end

        case (state)
            ST_IDLE: begin
                bit_nxt  = '0;
                byte_nxt = '0;
                good_nxt = '0;
                miss_nxt = '0;
                if (start) begin
                    state_nxt = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                // The detect edge itself is bit 0 of byte 0 of the frame.
                if (comma_ok) begin
                    bit_nxt   = 3'd1;
                    byte_nxt  = 4'd1;
                    good_nxt  = 4'd1;
                    state_nxt = (LOCK_CNT == 1) ? ST_LOCK : ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (comma_slot) begin
                    if (comma_ok) begin
                        good_nxt = good_cnt + 4'd1;
                        if (good_cnt + 4'd1 == LOCK_TGT) begin
                            state_nxt = ST_LOCK;
                        end
                    end else begin
                        good_nxt  = '0;
                        state_nxt = ST_SEARCH;
                    end
                end
            end
            ST_LOCK: begin
                if (comma_slot) begin
                    if (comma_ok) begin
                        miss_nxt = '0;
                    end else if (miss_cnt + 4'd1 == MISS_TGT) begin
                        miss_nxt  = '0;
                        good_nxt  = '0;
                        state_nxt = ST_SEARCH;
                    end else begin
                        miss_nxt = miss_cnt + 4'd1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Dropping start overrides whatever the current state decided.
        if (!start) begin
            state_nxt = ST_IDLE;
            bit_nxt   = '0;
            byte_nxt  = '0;
            good_nxt  = '0;
            miss_nxt  = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            DIR <= 1'b0;
        end else if (state == ST_IDLE) begin
            DIR <= dir_cfg;
        end
    end

    assign ENB    = (state != ST_IDLE);
    assign MODO   = (state != ST_IDLE) ? 2'b01 : 2'b00;
    assign LOCKED = (state == ST_LOCK);
    assign LOAD   = (state == ST_LOCK) && (bit_cnt == 3'd0);

`ifdef S2P_CTRL_ERR_CNT_EN
    logic       err_hit;
    logic [7:0] err_q;

    // A mismatch coinciding with start dropping is not counted: the run ends there.
    assign err_hit = (state == ST_LOCK) && comma_slot && !comma_ok && start;

    always_ff @(posedge CLK) begin
        if (reset) begin
            err_q <= '0;
        end else if (err_hit && err_q != 8'hFF) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_s2p_align_ctrl.sv
// Directed bench for s2p_align_ctrl (COMMA=BC, FRAME_LEN=4, LOCK_CNT=3).
// dut  : MISS_MAX=2, main sequencing/alignment scenarios.
// dut2 : MISS_MAX=15, held locked to exercise err_cnt saturation.
module tb_s2p_align_ctrl;

    localparam logic [7:0] FILL = 8'h55;
`ifdef S2P_CTRL_ERR_CNT_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic       CLK;
    logic       reset;
    logic       start;
    logic       start2;
    logic       dir_cfg;
    logic [7:0] P0;

    logic       ENB, DIR, LOAD, LOCKED;
    logic [1:0] MODO;
    logic [2:0] bit_cnt;
    logic [7:0] err_cnt;

    logic       ENB_b, DIR_b, LOAD_b, LOCKED_b;
    logic [1:0] MODO_b;
    logic [2:0] bit_cnt_b;
    logic [7:0] err_cnt_b;

    int vectors;
    int miscompares;

    s2p_align_ctrl dut (
        .CLK     (CLK),
        .reset   (reset),
        .start   (start),
        .dir_cfg (dir_cfg),
        .P0      (P0),
        .ENB     (ENB),
        .MODO    (MODO),
        .DIR     (DIR),
        .LOAD    (LOAD),
        .LOCKED  (LOCKED),
        .bit_cnt (bit_cnt),
        .err_cnt (err_cnt)
    );

    s2p_align_ctrl #(.MISS_MAX(15)) dut2 (
        .CLK     (CLK),
        .reset   (reset),
        .start   (start2),
        .dir_cfg (dir_cfg),
        .P0      (P0),
        .ENB     (ENB_b),
        .MODO    (MODO_b),
        .DIR     (DIR_b),
        .LOAD    (LOAD_b),
        .LOCKED  (LOCKED_b),
        .bit_cnt (bit_cnt_b),
        .err_cnt (err_cnt_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [7:0] b8(input logic x);
        return {7'b0, x};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive P0 for one edge; outputs are sampled 1 time unit after the edge.
    task automatic tick(input logic [7:0] p);
        P0 = p;
        @(posedge CLK);
        #1;
    endtask

    // One byte period: the byte value sits in P0 at its boundary edge, filler after.
    task automatic send_byte(input logic [7:0] b, input logic exp_lk, input logic exp_ld);
        for (int k = 1; k <= 8; k++) begin
            tick((k == 1) ? b : FILL);
            if (k == 1) chk("LOCKED", b8(LOCKED), b8(exp_lk));
            chk("LOAD", b8(LOAD), (k == 8) ? b8(exp_ld) : 8'h00);
        end
    endtask

    task automatic feed_byte(input logic [7:0] b);
        for (int k = 1; k <= 8; k++) tick((k == 1) ? b : FILL);
    endtask

    task automatic send_frame(input logic [7:0] c, input logic exp_lk, input logic exp_ld);
        send_byte(c,     exp_lk, exp_ld);
        send_byte(8'h11, exp_lk, exp_ld);
        send_byte(8'h22, exp_lk, exp_ld);
        send_byte(8'h33, exp_lk, exp_ld);
    endtask

    // From SEARCH: detect, two more commas, lock on the third, one locked frame after.
    task automatic lock_frames();
        send_frame(8'hBC, 1'b0, 1'b0);
        send_frame(8'hBC, 1'b0, 1'b0);
        send_frame(8'hBC, 1'b1, 1'b1);
        send_frame(8'hBC, 1'b1, 1'b1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset   = 1'b1;
        start   = 1'b1;
        start2  = 1'b0;
        dir_cfg = 1'b1;
        P0      = 8'h00;

        // Reset wins over start and dir_cfg.
        tick(FILL);
        tick(FILL);
        chk("rst_ENB",    b8(ENB),    8'h00);
        chk("rst_MODO",   {6'b0, MODO}, 8'h00);
        chk("rst_DIR",    b8(DIR),    8'h00);
        chk("rst_LOAD",   b8(LOAD),   8'h00);
        chk("rst_LOCKED", b8(LOCKED), 8'h00);
        chk("rst_bitcnt", {5'b0, bit_cnt}, 8'h00);
        chk("rst_errcnt", err_cnt,    8'h00);
        chk("rst_LOCKED_b", b8(LOCKED_b), 8'h00);

        // Start: running one edge later, DIR captured from dir_cfg.
        reset = 1'b0;
        tick(FILL);
        chk("run_ENB",    b8(ENB),    8'h01);
        chk("run_MODO",   {6'b0, MODO}, 8'h01);
        chk("run_DIR",    b8(DIR),    8'h01);
        chk("run_LOCKED", b8(LOCKED), 8'h00);
        dir_cfg = 1'b0;

        // Lock after the third comma boundary, strobes every byte once locked.
        lock_frames();
        chk("dir_held", b8(DIR), 8'h01);
        chk("lock_bitcnt", {5'b0, bit_cnt}, 8'h00);

        // Single corrupted comma while locked: lock held.
        send_frame(8'h3C, 1'b1, 1'b1);
        send_frame(8'hBC, 1'b1, 1'b1);
        chk("err_single", err_cnt, ERR_EN ? 8'h01 : 8'h00);

        // Two consecutive corrupted commas: lock lost at the second.
        send_frame(8'h3C, 1'b1, 1'b1);
        send_byte(8'h3C, 1'b0, 1'b0);
        chk("err_double", err_cnt, ERR_EN ? 8'h03 : 8'h00);
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        send_byte(8'h33, 1'b0, 1'b0);

        // SYNC: second comma bad -> back to SEARCH, no lock and no strobe.
        send_frame(8'hBC, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0);
        chk("sync_fail_LOCKED", b8(LOCKED), 8'h00);

        // Relock needs three fresh commas.
        send_frame(8'hBC, 1'b0, 1'b0);
        send_frame(8'hBC, 1'b0, 1'b0);
        send_frame(8'hBC, 1'b1, 1'b1);
        chk("relock_err", err_cnt, ERR_EN ? 8'h03 : 8'h00);

        // start=0 mid-byte while locked.
        tick(8'hBC);
        tick(FILL);
        tick(FILL);
        chk("mid_bitcnt", {5'b0, bit_cnt}, 8'h03);
        start = 1'b0;
        tick(FILL);
        chk("stop_ENB",    b8(ENB),    8'h00);
        chk("stop_MODO",   {6'b0, MODO}, 8'h00);
        chk("stop_LOCKED", b8(LOCKED), 8'h00);
        chk("stop_LOAD",   b8(LOAD),   8'h00);
        chk("stop_bitcnt", {5'b0, bit_cnt}, 8'h00);
        chk("stop_DIR",    b8(DIR),    8'h01);
        chk("stop_errcnt", err_cnt, ERR_EN ? 8'h03 : 8'h00);
        tick(FILL);
        chk("idle_DIR", b8(DIR), 8'h00);

        // Restart, relock, then reset mid-byte.
        dir_cfg = 1'b1;
        start   = 1'b1;
        tick(FILL);
        chk("restart_DIR", b8(DIR), 8'h01);
        lock_frames();
        tick(8'hBC);
        tick(FILL);
        reset = 1'b1;
        tick(FILL);
        chk("rst2_ENB",    b8(ENB),    8'h00);
        chk("rst2_MODO",   {6'b0, MODO}, 8'h00);
        chk("rst2_LOCKED", b8(LOCKED), 8'h00);
        chk("rst2_LOAD",   b8(LOAD),   8'h00);
        chk("rst2_errcnt", err_cnt,    8'h00);
        chk("rst2_DIR",    b8(DIR),    8'h00);
        reset = 1'b0;

        // Saturation on the MISS_MAX=15 instance: 14 bad commas then 1 good, repeated.
        start  = 1'b0;
        start2 = 1'b1;
        tick(FILL);
        for (int f = 0; f < 3; f++) begin
            feed_byte(8'hBC);
            feed_byte(8'h11);
            feed_byte(8'h22);
            feed_byte(8'h33);
        end
        chk("sat_lock", b8(LOCKED_b), 8'h01);
        for (int r = 0; r < 22; r++) begin
            for (int f = 0; f < 14; f++) begin
                feed_byte(8'h3C);
                feed_byte(8'h11);
                feed_byte(8'h22);
                feed_byte(8'h33);
            end
            feed_byte(8'hBC);
            feed_byte(8'h11);
            feed_byte(8'h22);
            feed_byte(8'h33);
            if (r == 0) chk("sat_first_round", err_cnt_b, ERR_EN ? 8'h0E : 8'h00);
        end
        chk("sat_held", b8(LOCKED_b), 8'h01);
        chk("sat_errcnt", err_cnt_b, ERR_EN ? 8'hFF : 8'h00);
        chk("idle_dut_ENB", b8(ENB), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
